// File: rtl/range_stack.sv
// LIFO stack of (lo,hi) pairs with registered pop outputs, same-cycle
// push+pop replace/bypass, and sticky overflow/underflow flags.
module range_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    input  logic [W-1:0]  lo_in,
    input  logic [W-1:0]  hi_in,
    output logic [W-1:0]  lo_out,
    output logic [W-1:0]  hi_out,
    output logic          out_valid,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_SWAP,
        OP_BYPASS,
        OP_OVF,
        OP_UNF
    } op_e;

    op_e           op;
    logic [AW-1:0] top_addr;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  lo_mem [DEPTH];
    logic [W-1:0]  hi_mem [DEPTH];

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Every push/pop combination resolves to exactly one operation per cycle.
    always_comb begin
        op = OP_NONE;
        if (push && pop) begin
            op = empty ? OP_BYPASS : OP_SWAP;
        end else if (push) begin
            op = full ? OP_OVF : OP_PUSH;
        end else if (pop) begin
            op = empty ? OP_UNF : OP_POP;
        end
    end

    always_comb begin
        top_addr = AW'(count - CW'(1));
        wr_addr  = (op == OP_PUSH) ? AW'(count) : top_addr;
    end

    // NOTE: storage has no reset; clearing count is enough to discard its contents.
    always_ff @(posedge clk) begin
        if (!rst && (op == OP_PUSH || op == OP_SWAP)) begin
            lo_mem[wr_addr] <= lo_in;
            hi_mem[wr_addr] <= hi_in;
        end
    end

    // NOTE: non-blocking assignments so a swap reads the old top before it is overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            lo_out    <= '0;
            hi_out    <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (op)
                OP_PUSH: begin
                    count <= count + CW'(1);
                end
                OP_POP: begin
                    lo_out    <= lo_mem[top_addr];
                    hi_out    <= hi_mem[top_addr];
                    out_valid <= 1'b1;
                    count     <= count - CW'(1);
                end
                OP_SWAP: begin
                    lo_out    <= lo_mem[top_addr];
                    hi_out    <= hi_mem[top_addr];
                    out_valid <= 1'b1;
                end
                OP_BYPASS: begin
                    lo_out    <= lo_in;
                    hi_out    <= hi_in;
                    out_valid <= 1'b1;
                end
                default: begin
                end
            endcase

            // Clearing wins over an error raised in the same cycle.
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (op == OP_OVF) overflow  <= 1'b1;
                if (op == OP_UNF) underflow <= 1'b1;
            end
        end
    end

endmodule
